fifo_drain: RTL and testbench

Read-side controller for `fifo_syn`. It pops words from the synchronous FIFO through the FIFO's native `cs`/`rd_en`/`empty`/`data_out` port and presents them downstream as a valid/ready stream. A 2-entry output buffer absorbs the FIFO's one-cycle read latency, so the block sustains one word per cycle while never over-reading and never dropping a word under backpressure. It sits between `fifo_syn` and any consumer block.

---
 rtl/fifo_drain_pkg.sv | 13 +
 rtl/fifo_drain_skid.sv | 60 ++++++
 rtl/fifo_drain.sv | 87 ++++++++
 tb/tb_fifo_drain.sv | 349 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_drain_pkg.sv
// fifo_drain_pkg
//   Shared types and constants for the fifo_drain read-side controller.
//   BUF_DEPTH          : depth of the output skid buffer
//   DEFAULT_DATA_WIDTH : default word width, matches fifo_syn
//   buf_cnt_t          : occupancy of the skid buffer (0..2)
package fifo_drain_pkg;

   localparam int BUF_DEPTH          = 2;
   localparam int DEFAULT_DATA_WIDTH = 32;

   typedef logic [1:0] buf_cnt_t;

endpackage

// File: rtl/fifo_drain_skid.sv
// fifo_drain_skid
//   Two-entry ordered buffer. entry0 is always the oldest word, so the head
//   output is a plain register and stays stable while it is not popped.
//   clk       : clock
//   rst       : synchronous active-high reset
//   wr_en     : write wr_data into the tail this cycle
//   wr_data   : word to write
//   pop       : remove the head word this cycle
//   count     : number of stored words
//   head_data : oldest stored word
module fifo_drain_skid
   import fifo_drain_pkg::*;
#(
   parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  wr_en,
   input  logic [DATA_WIDTH-1:0] wr_data,
   input  logic                  pop,
   output buf_cnt_t              count,
   output logic [DATA_WIDTH-1:0] head_data
);

   logic [DATA_WIDTH-1:0] entry0;
   logic [DATA_WIDTH-1:0] entry1;

   always_ff @(posedge clk) begin
      if (rst) begin
         count  <= 2'd0;
         entry0 <= '0;
         entry1 <= '0;
      end else begin
         case ({wr_en, pop})
            2'b10: begin
               if (count == 2'd0) entry0 <= wr_data;
               else               entry1 <= wr_data;
               count <= count + 2'd1;
            end
            2'b01: begin
               entry0 <= entry1;
               count  <= count - 2'd1;
            end
            2'b11: begin
               // Count unchanged; the new word goes behind whatever remains.
               if (count == 2'd1) begin
                  entry0 <= wr_data;
               end else begin
                  entry0 <= entry1;
                  entry1 <= wr_data;
               end
            end
            default: ;
         endcase
      end
   end

   assign head_data = entry0;

endmodule

// File: rtl/fifo_drain.sv
// fifo_drain
//   Read-side controller for fifo_syn. Pops words through the FIFO's native
//   cs/rd_en/empty/data_out port and presents them as a valid/ready stream.
//   A 2-entry skid buffer absorbs the FIFO's one-cycle read latency.
//   Optional feature macro: FIFO_DRAIN_CNT_EN adds the CNT_WIDTH parameter,
//   the word_cnt port and the delivered-word counter.
//   clk        : clock, shared with fifo_syn
//   rst        : synchronous active-high reset
//   en         : drain enable; gates new FIFO reads only
//   fifo_empty : fifo_syn.empty
//   fifo_data  : fifo_syn.data_out
//   fifo_cs    : fifo_syn.cs (equals fifo_rd_en)
//   fifo_rd_en : fifo_syn.rd_en, combinational pop request
//   m_valid    : output word valid
//   m_data     : output word (oldest buffered)
//   m_ready    : downstream accepts
//   word_cnt   : delivered-word count (FIFO_DRAIN_CNT_EN only)
module fifo_drain
   import fifo_drain_pkg::*;
#(
   parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
`ifdef FIFO_DRAIN_CNT_EN
   ,
   parameter int CNT_WIDTH  = 16
`endif
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  en,
   input  logic                  fifo_empty,
   input  logic [DATA_WIDTH-1:0] fifo_data,
   output logic                  fifo_cs,
   output logic                  fifo_rd_en,
   output logic                  m_valid,
   output logic [DATA_WIDTH-1:0] m_data,
   input  logic                  m_ready
`ifdef FIFO_DRAIN_CNT_EN
   ,
   output logic [CNT_WIDTH-1:0]  word_cnt
`endif
);

   buf_cnt_t   buf_cnt;
   logic       inflight;
   logic       pop;
   logic [2:0] occupancy;
   logic [2:0] credit_limit;

   assign pop = m_valid & m_ready;

   // Credit rule: buffered + in-flight words, less the one leaving now,
   // must stay below the buffer depth. Written as occ < depth + pop to keep
   // the arithmetic unsigned.
   assign occupancy    = {1'b0, buf_cnt} + {2'b00, inflight};
   assign credit_limit = 3'(BUF_DEPTH) + {2'b00, pop};

   assign fifo_rd_en = ~rst & en & ~fifo_empty & (occupancy < credit_limit);
   assign fifo_cs    = fifo_rd_en;

   // A read issued this cycle means fifo_data carries the word next cycle.
   always_ff @(posedge clk) begin
      if (rst) inflight <= 1'b0;
      else     inflight <= fifo_rd_en;
   end

   fifo_drain_skid #(
      .DATA_WIDTH (DATA_WIDTH)
   ) u_skid (
      .clk       (clk),
      .rst       (rst),
      .wr_en     (inflight),
      .wr_data   (fifo_data),
      .pop       (pop),
      .count     (buf_cnt),
      .head_data (m_data)
   );

   assign m_valid = (buf_cnt != 2'd0);

`ifdef FIFO_DRAIN_CNT_EN
   always_ff @(posedge clk) begin
      if (rst)      word_cnt <= '0;
      else if (pop) word_cnt <= word_cnt + 1'b1;
   end
`endif

endmodule

// File: tb/tb_fifo_drain.sv
// tb_fifo_drain
//   Self-checking bench for fifo_drain. A behavioural fifo_syn (depth 8,
//   registered empty, one-cycle read latency) feeds the DUT; every word
//   written into it is expected at the stream output exactly once, in order.
module tb_fifo_drain;

   localparam int DW         = 32;
   localparam int CW         = 16;
   localparam int FIFO_DEPTH = 8;

   logic          clk = 1'b0;
   logic          rst;
   logic          en;
   logic          m_ready;
   logic          f_wr;
   logic [DW-1:0] f_wdata;
   logic          ovr_nonempty;
   logic          fifo_empty_m = 1'b1;
   logic          dut_empty;
   logic [DW-1:0] fifo_data;
   logic          fifo_cs;
   logic          fifo_rd_en;
   logic          m_valid;
   logic [DW-1:0] m_data;
`ifdef FIFO_DRAIN_CNT_EN
   logic [CW-1:0] word_cnt;
`endif

   always #5 clk = ~clk;

   assign dut_empty = fifo_empty_m & ~ovr_nonempty;

   fifo_drain #(
      .DATA_WIDTH (DW)
`ifdef FIFO_DRAIN_CNT_EN
      , .CNT_WIDTH (CW)
`endif
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .en         (en),
      .fifo_empty (dut_empty),
      .fifo_data  (fifo_data),
      .fifo_cs    (fifo_cs),
      .fifo_rd_en (fifo_rd_en),
      .m_valid    (m_valid),
      .m_data     (m_data),
      .m_ready    (m_ready)
`ifdef FIFO_DRAIN_CNT_EN
      , .word_cnt (word_cnt)
`endif
   );

   // Behavioural fifo_syn
   logic [DW-1:0] fifo_q[$];

   always @(posedge clk) begin
      if (rst) begin
         fifo_q.delete();
         fifo_data    <= '0;
         fifo_empty_m <= 1'b1;
      end else begin
         if (fifo_rd_en && fifo_q.size() > 0) fifo_data <= fifo_q.pop_front();
         if (f_wr && fifo_q.size() < FIFO_DEPTH) fifo_q.push_back(f_wdata);
         fifo_empty_m <= (fifo_q.size() == 0);
      end
   end

   // Transaction recorder, sampled mid-cycle
   int            cyc = 0;
   logic [DW-1:0] out_q[$];
   int            pop_cyc[$];
   int            rd_cnt;
   int            first_rd;
   int            first_val;
   int            hold_viol;
   int            bad_rd;
   logic          stall_prev = 1'b0;
   logic [DW-1:0] stall_data;

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (!rst) begin
         if (m_valid && m_ready) begin
            out_q.push_back(m_data);
            pop_cyc.push_back(cyc);
         end
         if (fifo_rd_en) begin
            rd_cnt++;
            if (first_rd < 0) first_rd = cyc;
         end
         if (m_valid && first_val < 0) first_val = cyc;
         if (stall_prev && (!m_valid || m_data !== stall_data)) hold_viol++;
      end
      if (fifo_rd_en && (dut_empty || rst)) bad_rd++;
      stall_prev = !rst && m_valid && !m_ready;
      stall_data = m_data;
   end

   int            checks   = 0;
   int            failures = 0;
   int            exp_wc   = 0;
   logic [DW-1:0] exp_q[$];

   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         #2;
      end
   endtask

   task automatic clear_logs();
      out_q.delete();
      pop_cyc.delete();
      exp_q.delete();
      rd_cnt    = 0;
      first_rd  = -1;
      first_val = -1;
      hold_viol = 0;
      bad_rd    = 0;
   endtask

   task automatic push_word(input logic [DW-1:0] v);
      f_wr    = 1'b1;
      f_wdata = v;
      exp_q.push_back(v);
      step(1);
      f_wr    = 1'b0;
   endtask

   task automatic check_stream(input string name);
      checks++;
      if (out_q.size() !== exp_q.size()) begin
         failures++;
         $display("FAIL %s_count got=%0d exp=%0d", name, out_q.size(), exp_q.size());
      end else begin
         for (int i = 0; i < exp_q.size(); i++) begin
            checks++;
            if (out_q[i] !== exp_q[i]) begin
               failures++;
               $display("FAIL %s_data[%0d] got=%0h exp=%0h", name, i, out_q[i], exp_q[i]);
            end
         end
      end
   endtask

   task automatic check_wc(input string name);
`ifdef FIFO_DRAIN_CNT_EN
      checks++;
      if (word_cnt !== CW'(exp_wc)) begin
         failures++;
         $display("FAIL %s_word_cnt got=%0d exp=%0d", name, word_cnt, exp_wc);
      end
`else
      if (name.len() < 0) $display("%s", name);
`endif
   endtask

   task automatic test_reset();
      rst = 1'b1; en = 1'b1; m_ready = 1'b1; ovr_nonempty = 1'b1;
      f_wr = 1'b0; f_wdata = '0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         checks += 3;
         if (fifo_rd_en !== 1'b0) begin failures++; $display("FAIL reset_rd_en cyc%0d got=%b exp=0", i, fifo_rd_en); end
         if (m_valid !== 1'b0)    begin failures++; $display("FAIL reset_m_valid cyc%0d got=%b exp=0", i, m_valid); end
         if (m_data !== '0)       begin failures++; $display("FAIL reset_m_data cyc%0d got=%0h exp=0", i, m_data); end
         check_wc("reset");
      end
      step(1);
      rst = 1'b0; ovr_nonempty = 1'b0; en = 1'b0;
      exp_wc = 0;
      clear_logs();
      step(1);
   endtask

   task automatic test_basic();
      en = 1'b0; m_ready = 1'b1;
      clear_logs();
      for (int i = 1; i <= 4; i++) push_word(DW'(i));
      en = 1'b1;
      step(10);
      @(negedge clk);
      check_stream("basic");
      checks += 3;
      if (first_val - first_rd !== 2) begin
         failures++; $display("FAIL basic_latency got=%0d exp=2", first_val - first_rd);
      end
      if (pop_cyc.size() == 4 && pop_cyc[3] - pop_cyc[0] !== 3) begin
         failures++; $display("FAIL basic_throughput span got=%0d exp=3", pop_cyc[3] - pop_cyc[0]);
      end
      if (bad_rd !== 0) begin failures++; $display("FAIL basic_rd_when_empty got=%0d exp=0", bad_rd); end
      exp_wc += 4;
      check_wc("basic");
   endtask

   task automatic test_backpressure();
      step(1);
      en = 1'b0; m_ready = 1'b0;
      clear_logs();
      for (int i = 0; i < 8; i++) push_word(DW'(i));
      en = 1'b1;
      step(8);
      @(negedge clk);
      checks += 5;
      if (rd_cnt !== 2)        begin failures++; $display("FAIL bp_reads got=%0d exp=2", rd_cnt); end
      if (m_valid !== 1'b1)    begin failures++; $display("FAIL bp_m_valid got=%b exp=1", m_valid); end
      if (m_data !== '0)       begin failures++; $display("FAIL bp_m_data got=%0h exp=0", m_data); end
      if (fifo_q.size() !== 6) begin failures++; $display("FAIL bp_fifo_left got=%0d exp=6", fifo_q.size()); end
      if (hold_viol !== 0)     begin failures++; $display("FAIL bp_hold got=%0d exp=0", hold_viol); end
      step(1);
      m_ready = 1'b1;
      step(15);
      @(negedge clk);
      check_stream("bp");
      checks++;
      if (rd_cnt !== 8) begin failures++; $display("FAIL bp_total_reads got=%0d exp=8", rd_cnt); end
      exp_wc += 8;
      check_wc("bp");
   endtask

   task automatic test_interleaved();
      step(1);
      en = 1'b1; m_ready = 1'b0;
      clear_logs();
      for (int i = 0; i < FIFO_DEPTH; i++) begin
         push_word(DW'($urandom));
         step(2 + $urandom_range(0, 2));
         m_ready = 1'b1;
         step(1);
         m_ready = 1'b0;
         step(1);
      end
      step(3);
      @(negedge clk);
      check_stream("interleaved");
      checks += 2;
      if (bad_rd !== 0)    begin failures++; $display("FAIL il_rd_when_empty got=%0d exp=0", bad_rd); end
      if (hold_viol !== 0) begin failures++; $display("FAIL il_hold got=%0d exp=0", hold_viol); end
      exp_wc += FIFO_DEPTH;
      check_wc("interleaved");
   endtask

   task automatic test_enable_gating();
      step(1);
      en = 1'b0; m_ready = 1'b1;
      clear_logs();
      for (int i = 0; i < 4; i++) push_word(DW'($urandom));
      en = 1'b1;
      step(1);
      en = 1'b0;
      step(6);
      @(negedge clk);
      checks += 3;
      if (rd_cnt !== 1)        begin failures++; $display("FAIL en_reads got=%0d exp=1", rd_cnt); end
      if (fifo_q.size() !== 3) begin failures++; $display("FAIL en_fifo_left got=%0d exp=3", fifo_q.size()); end
      if (out_q.size() !== 1 || out_q[0] !== exp_q[0]) begin
         failures++;
         $display("FAIL en_single_word got_n=%0d exp_n=1 exp_word=%0h", out_q.size(), exp_q[0]);
      end
      step(1);
      en = 1'b1;
      step(8);
      @(negedge clk);
      check_stream("en_drain");
      exp_wc += 4;
      check_wc("en");
   endtask

   task automatic test_random();
      step(1);
      clear_logs();
      for (int c = 0; c < 400; c++) begin
         en      = ($urandom_range(0, 3) != 0);
         m_ready = $urandom_range(0, 1) == 1;
         if (fifo_q.size() < FIFO_DEPTH - 1 && $urandom_range(0, 1) == 1) begin
            f_wr    = 1'b1;
            f_wdata = DW'($urandom);
            exp_q.push_back(f_wdata);
         end else begin
            f_wr = 1'b0;
         end
         step(1);
      end
      f_wr = 1'b0; en = 1'b1; m_ready = 1'b1;
      step(20);
      @(negedge clk);
      check_stream("random");
      checks += 3;
      if (bad_rd !== 0)        begin failures++; $display("FAIL rnd_rd_when_empty got=%0d exp=0", bad_rd); end
      if (hold_viol !== 0)     begin failures++; $display("FAIL rnd_hold got=%0d exp=0", hold_viol); end
      if (fifo_q.size() !== 0) begin failures++; $display("FAIL rnd_fifo_left got=%0d exp=0", fifo_q.size()); end
      exp_wc += exp_q.size();
      check_wc("random");
   endtask

   task automatic test_reset_midstream();
      step(1);
      en = 1'b0; m_ready = 1'b0;
      clear_logs();
      for (int i = 0; i < 8; i++) push_word(DW'($urandom));
      en = 1'b1;
      step(5);
      // Buffer full; one pop now starts a read so a word is in flight
      m_ready = 1'b1;
      step(1);
      rst = 1'b1; m_ready = 1'b0; en = 1'b0;
      @(negedge clk);
      checks++;
      if (fifo_rd_en !== 1'b0) begin failures++; $display("FAIL rstmid_rd_en got=%b exp=0", fifo_rd_en); end
      step(1);
      rst = 1'b0;
      exp_wc = 0;
      @(negedge clk);
      checks += 2;
      if (m_valid !== 1'b0) begin failures++; $display("FAIL rstmid_m_valid got=%b exp=0", m_valid); end
      if (m_data !== '0)    begin failures++; $display("FAIL rstmid_m_data got=%0h exp=0", m_data); end
      check_wc("rstmid");
      step(2);
      @(negedge clk);
      checks++;
      if (m_valid !== 1'b0) begin failures++; $display("FAIL rstmid_inflight_dropped got=%b exp=0", m_valid); end
      step(1);
      clear_logs();
      m_ready = 1'b1;
      push_word(DW'(9));
      push_word(DW'(10));
      en = 1'b1;
      step(8);
      @(negedge clk);
      check_stream("rstmid_after");
      exp_wc += 2;
      check_wc("rstmid_after");
   endtask

   initial begin
      test_reset();
      test_basic();
      test_backpressure();
      test_interleaved();
      test_enable_gating();
      test_random();
      test_reset_midstream();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
